spi_load_sequencer: RTL and testbench

//   Synthesizable host-side sequencer that drives the Master_Top SPI master parallel port.

---
 rtl/spi_load_sequencer_if.sv | 24 ++
 rtl/spi_load_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_spi_load_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_load_sequencer_if.sv
// Parallel-port bundle between the load sequencer and the Master_Top SPI master.
// The sequencer uses the master modport; the SPI master (or a bench model) uses slave.
interface spi_load_sequencer_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] spi_addr;
  logic [DWIDTH-1:0] spi_wr_data;
  logic [DWIDTH-1:0] spi_nod;
  logic              spi_start;
  logic              spi_busy;
  logic              spi_word;
  logic              spi_done;
  logic [DWIDTH-1:0] spi_rd_data;

  modport master (
    output spi_addr, spi_wr_data, spi_nod, spi_start,
    input  spi_busy, spi_word, spi_done, spi_rd_data
  );

  modport slave (
    input  spi_addr, spi_wr_data, spi_nod, spi_start,
    output spi_busy, spi_word, spi_done, spi_rd_data
  );
endinterface

// File: rtl/spi_load_sequencer.sv
// Streams image/filter/weight bytes from a local ROM through the SPI master, starts the CNN,
// then reads the result words back. ROM bytes are consumed strictly in transaction order.
module spi_load_sequencer #(
  parameter int DWIDTH    = 16,
  parameter int RAW       = 12,
  parameter int IMG_ROWS  = 28,
  parameter int FLT_BANKS = 4,
  parameter int FLT_ROWS  = 3,
  parameter int W1_NEUR   = 10,
  parameter int W2_NEUR   = 14,
  parameter int RD_NOD    = 15
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  go,
  output logic [RAW-1:0]        rom_addr,
  input  logic [7:0]            rom_data,
  spi_load_sequencer_if.master  spi,
  output logic                  cnn_start,
  input  logic                  cnn_finish,
  output logic [DWIDTH-1:0]     res_data,
  output logic                  res_valid,
  output logic [3:0]            res_idx,
  output logic                  busy,
  output logic                  done
);
  localparam int W1_NOD = 7;
  localparam int W2_NOD = 10;

  typedef enum logic [2:0] {IDLE, PREF, ISSUE, XFER, NEXT, RUN, READ, RWAIT} state_t;

  state_t            state_q;
  logic [1:0]        seg_q;
  logic [4:0]        row_q;
  logic [3:0]        n_q;
  logic [RAW-1:0]    rom_addr_q;
  logic              pf_q;
  logic [1:0]        fetch_q;
  logic [DWIDTH-1:0] words_q;
  logic [3:0]        rd_cnt_q;
  logic              run_armed_q;
  logic              fin_prev_q;
  logic [DWIDTH-1:0] spi_addr_q, spi_wr_data_q, spi_nod_q, res_data_q;
  logic              spi_start_q, cnn_start_q, res_valid_q, busy_q, done_q;
  logic [3:0]        res_idx_q;

  logic [DWIDTH-1:0] addr_d, nod_d;
  logic              last_word, final_txn;

  always_comb begin
    addr_d = '0;
    nod_d  = '0;
    unique case (seg_q)
      2'd0: begin
        addr_d = DWIDTH'({1'b1, 3'b000, 2'b00, row_q, 5'b00000});
        nod_d  = DWIDTH'(IMG_ROWS);
      end
      2'd1: begin
        addr_d = DWIDTH'({1'b1, 3'b001, 6'b000000, n_q[1:0], row_q[1:0], 2'b00});
        nod_d  = DWIDTH'(FLT_ROWS);
      end
      2'd2: begin
        addr_d = DWIDTH'({1'b1, 3'b010, n_q, row_q, 3'b000});
        nod_d  = DWIDTH'(W1_NOD);
      end
      default: begin
        addr_d = DWIDTH'({1'b1, 3'b011, n_q, 8'h00});
        nod_d  = DWIDTH'(W2_NOD);
      end
    endcase
  end

  assign last_word = (words_q == spi_nod_q - DWIDTH'(1));
  // The very last ROM byte is not followed by another, so the pointer parks on it.
  assign final_txn = (seg_q == 2'd3) && (n_q == 4'(W2_NEUR));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= IDLE;
      seg_q         <= '0;
      row_q         <= '0;
      n_q           <= '0;
      rom_addr_q    <= '0;
      pf_q          <= 1'b0;
      fetch_q       <= '0;
      words_q       <= '0;
      rd_cnt_q      <= '0;
      run_armed_q   <= 1'b0;
      fin_prev_q    <= 1'b0;
      spi_addr_q    <= '0;
      spi_wr_data_q <= '0;
      spi_nod_q     <= '0;
      res_data_q    <= '0;
      spi_start_q   <= 1'b0;
      cnn_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_idx_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      cnn_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fin_prev_q  <= cnn_finish;
      fetch_q     <= {fetch_q[0], 1'b0};
      // Two-stage fetch: address presented, ROM registers it, then the byte is latched.
      if (fetch_q[1]) spi_wr_data_q <= DWIDTH'(rom_data);

      unique case (state_q)
        IDLE: if (go) begin
          busy_q     <= 1'b1;
          rom_addr_q <= '0;
          seg_q      <= '0;
          row_q      <= '0;
          n_q        <= '0;
          pf_q       <= 1'b0;
          state_q    <= PREF;
        end
        PREF: if (!pf_q) begin
          pf_q <= 1'b1;
        end else begin
          pf_q          <= 1'b0;
          spi_wr_data_q <= DWIDTH'(rom_data);
          state_q       <= ISSUE;
        end
        ISSUE: if (!spi.spi_busy) begin
          spi_addr_q  <= addr_d;
          spi_nod_q   <= nod_d;
          spi_start_q <= 1'b1;
          words_q     <= '0;
          state_q     <= XFER;
        end
        XFER: begin
          if (spi.spi_word) begin
            words_q <= words_q + DWIDTH'(1);
            if (!(last_word && final_txn)) rom_addr_q <= rom_addr_q + RAW'(1);
            if (!last_word) fetch_q <= {fetch_q[0], 1'b1};
          end
          if (spi.spi_done) state_q <= NEXT;
        end
        NEXT: begin
          state_q <= PREF;
          unique case (seg_q)
            2'd0: if (row_q == 5'(IMG_ROWS - 1)) begin
              seg_q <= 2'd1;
              row_q <= '0;
              n_q   <= '0;
            end else row_q <= row_q + 5'd1;
            2'd1: if (row_q == 5'(FLT_ROWS - 1)) begin
              row_q <= '0;
              if (n_q == 4'(FLT_BANKS - 1)) begin
                seg_q <= 2'd2;
                n_q   <= 4'd1;
              end else n_q <= n_q + 4'd1;
            end else row_q <= row_q + 5'd1;
            2'd2: if (row_q == 5'(IMG_ROWS - 1)) begin
              row_q <= '0;
              if (n_q == 4'(W1_NEUR)) begin
                seg_q <= 2'd3;
                n_q   <= 4'd1;
              end else n_q <= n_q + 4'd1;
            end else row_q <= row_q + 5'd1;
            default: if (n_q == 4'(W2_NEUR)) begin
              run_armed_q <= 1'b0;
              state_q     <= RUN;
            end else n_q <= n_q + 4'd1;
          endcase
        end
        // Only a rising edge of finish after the start pulse counts.
        RUN: if (!run_armed_q) begin
          cnn_start_q <= 1'b1;
          run_armed_q <= 1'b1;
        end else if (cnn_finish && !fin_prev_q) begin
          state_q <= READ;
        end
        READ: if (!spi.spi_busy) begin
          spi_addr_q    <= DWIDTH'({1'b0, 3'b100, 8'h00, 4'h1});
          spi_nod_q     <= DWIDTH'(RD_NOD);
          spi_wr_data_q <= '0;
          spi_start_q   <= 1'b1;
          rd_cnt_q      <= '0;
          state_q       <= RWAIT;
        end
        // Completion is signalled straight from here so a go on the next cycle is accepted.
        RWAIT: begin
          if (spi.spi_word) begin
            res_data_q  <= spi.spi_rd_data;
            res_valid_q <= 1'b1;
            res_idx_q   <= rd_cnt_q;
            rd_cnt_q    <= rd_cnt_q + 4'd1;
          end
          if (spi.spi_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr        = rom_addr_q;
  assign spi.spi_addr    = spi_addr_q;
  assign spi.spi_wr_data = spi_wr_data_q;
  assign spi.spi_nod     = spi_nod_q;
  assign spi.spi_start   = spi_start_q;
  assign cnn_start       = cnn_start_q;
  assign res_data        = res_data_q;
  assign res_valid       = res_valid_q;
  assign res_idx         = res_idx_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule

// File: tb/tb_spi_load_sequencer.sv
// Bench for spi_load_sequencer: behavioural SPI master, CNN and ROM models with a
// transaction list derived from the segment rules, under randomized handshake timing.
module tb_spi_load_sequencer;
  localparam int DW     = 16;
  localparam int RAW    = 12;
  localparam int NWR    = 334;
  localparam int NTX    = 335;
  localparam int NBYTES = 2920;
  localparam int RDN    = 15;

  logic           clk = 1'b0;
  logic           nRst, go;
  logic [RAW-1:0] rom_addr;
  logic [7:0]     rom_data;
  logic           cnn_start, cnn_finish;
  logic [DW-1:0]  res_data;
  logic           res_valid;
  logic [3:0]     res_idx;
  logic           busy, done;

  spi_load_sequencer_if #(.DWIDTH(DW)) spi ();

  spi_load_sequencer dut (
    .clk(clk), .nRst(nRst), .go(go), .rom_addr(rom_addr), .rom_data(rom_data),
    .spi(spi.master), .cnn_start(cnn_start), .cnn_finish(cnn_finish),
    .res_data(res_data), .res_valid(res_valid), .res_idx(res_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [4096];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total, bad;
  logic [15:0] exp_addr [$];
  int          exp_nod  [$];
  logic [15:0] exp_rd   [$];
  int n_tx, ptr, n_res, n_cnn, n_done;
  bit rd_fixed, pre_fin, abort_hit;

  int rph, rk, rnod, rgap, rdly, rhold, cph, cwait;
  bit ris_rd;
  logic [15:0] raddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction list from the segment rules, written as plain address arithmetic.
  task automatic prep(input bit fixed_rd, input bit early_fin);
    exp_addr.delete(); exp_nod.delete(); exp_rd.delete();
    for (int r = 0; r < 28; r++) begin exp_addr.push_back(16'(32'h8000 + r*32)); exp_nod.push_back(28); end
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 3; r++) begin exp_addr.push_back(16'(32'h9000 + k*16 + r*4)); exp_nod.push_back(3); end
    for (int n = 1; n <= 10; n++)
      for (int r = 0; r < 28; r++) begin exp_addr.push_back(16'(32'hA000 + n*256 + r*8)); exp_nod.push_back(7); end
    for (int n = 1; n <= 14; n++) begin exp_addr.push_back(16'(32'hB000 + n*256)); exp_nod.push_back(10); end
    exp_addr.push_back(16'h4001); exp_nod.push_back(RDN);
    n_tx = 0; ptr = 0; n_res = 0; n_cnn = 0; n_done = 0;
    rd_fixed = fixed_rd; pre_fin = early_fin; abort_hit = 0;
  endtask

  task automatic resp_step();
    spi.spi_word = 1'b0;
    spi.spi_done = 1'b0;
    case (rph)
      0: if (spi.spi_start) begin
        chk("txn_in_range", 32'(n_tx < NTX), 1);
        if (exp_addr.size() > 0) begin
          raddr = exp_addr.pop_front();
          rnod  = exp_nod.pop_front();
          chk("txn_addr", spi.spi_addr, raddr);
          chk("txn_nod", spi.spi_nod, rnod);
          ris_rd = (n_tx == NWR);
          if (ris_rd) chk("rd_wrdata", spi.spi_wr_data, 0);
          if (raddr == 16'hA128) abort_hit = 1;
          if (pre_fin && n_tx == NWR - 1) cnn_finish = 1'b1;
          n_tx++;
          rk = 0; rgap = $urandom_range(0, 3); spi.spi_busy = 1'b1; rph = 1;
        end
      end
      1: if (rgap > 0) rgap--;
      else begin
        chk("addr_held", spi.spi_addr, raddr);
        if (ris_rd) begin
          spi.spi_rd_data = rd_fixed ? 16'(rk + 1) : 16'($urandom);
          exp_rd.push_back(spi.spi_rd_data);
        end else begin
          chk("wr_data", spi.spi_wr_data, {8'h00, rom[ptr]});
          ptr++;
        end
        spi.spi_word = 1'b1;
        rk++;
        rgap = $urandom_range(2, 4);
        if (rk == rnod) begin
          if ($urandom_range(0, 1) == 1) begin
            spi.spi_done = 1'b1; rhold = $urandom_range(0, 3); rph = 3;
          end else begin
            rdly = $urandom_range(0, 2); rph = 2;
          end
        end
      end
      2: if (rdly > 0) rdly--;
      else begin spi.spi_done = 1'b1; rhold = $urandom_range(0, 3); rph = 3; end
      default: begin
        chk("start_busy", spi.spi_start, 0);
        if (rhold > 0) rhold--;
        else begin spi.spi_busy = 1'b0; rph = 0; end
      end
    endcase
  endtask

  task automatic cnn_step();
    case (cph)
      0: if (cnn_start) begin
        n_cnn++;
        chk("cnn_after_writes", n_tx, NWR);
        chk("cnn_rom_end", rom_addr, NBYTES - 1);
        cwait = $urandom_range(3, 8); cph = 1;
      end
      1: begin
        chk("cnn_start_once", cnn_start, 0);
        if (cwait > 0) cwait--;
        else begin
          chk("finish_early_ignored", n_tx, NWR);
          cnn_finish = 1'b0; cwait = $urandom_range(1, 5); cph = 2;
        end
      end
      2: if (cwait > 0) cwait--; else begin cnn_finish = 1'b1; cwait = 3; cph = 3; end
      3: if (cwait > 0) cwait--; else begin cnn_finish = 1'b0; cph = 4; end
      default: if (cnn_start) n_cnn++;
    endcase
  endtask

  task automatic mon_step();
    if (res_valid) begin
      chk("res_in_range", 32'(exp_rd.size() > 0), 1);
      if (exp_rd.size() > 0) chk("res_data", res_data, exp_rd.pop_front());
      chk("res_idx", res_idx, n_res);
      n_res++;
    end
    if (done) begin
      n_done++;
      chk("busy_at_done", busy, 0);
      chk("res_count", n_res, RDN);
    end
  endtask

  initial begin
    rph = 0; cph = 0;
    spi.spi_busy = 1'b0; spi.spi_word = 1'b0; spi.spi_done = 1'b0; spi.spi_rd_data = '0;
    cnn_finish = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!nRst) begin
        rph = 0; cph = 0;
        spi.spi_busy = 1'b0; spi.spi_word = 1'b0; spi.spi_done = 1'b0; spi.spi_rd_data = '0;
        cnn_finish = 1'b0;
      end else begin
        resp_step();
        cnn_step();
        mon_step();
      end
    end
  end

  task automatic pulse_go();
    @(posedge clk); #2 go = 1'b1;
    @(posedge clk); #2 go = 1'b0;
    chk("busy_after_go", busy, 1);
  endtask

  task automatic wait_done(input int lim);
    int c;
    c = 0;
    while (n_done == 0 && c < lim) begin @(posedge clk); #2; c++; end
    chk("done_seen", n_done, 1);
    chk("tx_total", n_tx, NTX);
    chk("cnn_pulses", n_cnn, 1);
    chk("bytes_used", ptr, NBYTES);
    @(posedge clk); #2;
    chk("done_pulse_len", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int c;
    total = 0; bad = 0;
    nRst = 1'b0; go = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'(i);
    prep(1, 1);
    repeat (3) @(posedge clk); #2;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_spi_start", spi.spi_start, 0);
    chk("rst_spi_addr", spi.spi_addr, 0);
    chk("rst_spi_wr_data", spi.spi_wr_data, 0);
    chk("rst_spi_nod", spi.spi_nod, 0);
    chk("rst_cnn_start", cnn_start, 0);
    chk("rst_res", {res_valid, res_idx, res_data}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #3 nRst = 1'b1;

    // Full sequence with ROM[i]=i, results 1..15, finish already high before the CNN pulse.
    pulse_go();
    repeat (4) @(posedge clk);
    #2 go = 1'b1;
    @(posedge clk); #2 go = 1'b0;
    wait_done(40000);

    // Abort during weight1 neuron 1 row 5, then restart from the beginning.
    for (int i = 0; i < NBYTES; i++) rom[i] = 8'($urandom);
    prep(0, 0);
    pulse_go();
    c = 0;
    while (!abort_hit && c < 20000) begin @(posedge clk); #2; c++; end
    chk("abort_reached", abort_hit, 1);
    repeat ($urandom_range(0, 6)) @(posedge clk);
    @(posedge clk); #3 nRst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_spi_start", spi.spi_start, 0);
    repeat (2) @(posedge clk);
    #3 nRst = 1'b1;
    prep(0, 0);
    pulse_go();
    wait_done(40000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
